// File: rtl/mcash_pkg.sv
// mcash shared types and constants.
// Write-buffer geometry and entry layout.
package mcash_pkg;

  localparam int WBUF_DEPTH = 256;
  localparam int WBUF_ID_W  = 8;
  localparam int DATA_W     = 128;
  localparam int CH_ID_W    = 2;
  localparam int NUM_CH     = 3;

  typedef logic [WBUF_ID_W-1:0] wbuf_id_t;

  typedef struct packed {
    logic [CH_ID_W-1:0] ch_id;
    logic [DATA_W-1:0]  data;
  } wbuf_entry_t;

endpackage

// File: rtl/mcash_wbuf_ram.sv
// Single-port write-buffer storage, one access per cycle.
// Read wins over write; read data is registered.
module mcash_wbuf_ram #(
  parameter int DEPTH = 256,
  parameter int ID_W  = 8,
  parameter int W     = 130
) (
  input  logic            clk_i,
  input  logic            rd_i,
  input  logic            wr_i,
  input  logic [ID_W-1:0] addr_i,
  input  logic [W-1:0]    wdata_i,
  output logic [W-1:0]    rdata_o
);

  logic [W-1:0] mem [DEPTH];

  // One read-or-write per edge; the array itself is never reset.
  always_ff @(posedge clk_i) begin
    if (rd_i) begin
      rdata_o <= mem[addr_i];
    end else if (wr_i) begin
      mem[addr_i] <= wdata_i;
    end
  end

endmodule

// File: rtl/mcash_wbuffer.sv
// Write-data buffer between the cross bar and the banks.
// Tracks occupancy, returns reads and pulses freed ids.
module mcash_wbuffer #(
  parameter int DEPTH  = mcash_pkg::WBUF_DEPTH,
  parameter int ID_W   = mcash_pkg::WBUF_ID_W,
  parameter int DATA_W = mcash_pkg::DATA_W
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                xbar_wbuf_req_valid_i,
  output logic                xbar_wbuf_req_ready_o,
  input  logic [1:0]          xbar_wbuf_req_ch_id_i,
  input  logic [DATA_W-1:0]   xbar_wbuf_req_data_i,
  input  logic [ID_W-1:0]     xbar_wbuf_req_wbuffer_id_i,
  output logic [DEPTH-1:0]    xbar_wbuf_rtn_free_id_o,
  input  logic                bank_wbuf_rd_valid_i,
  input  logic [ID_W-1:0]     bank_wbuf_rd_id_i,
  input  logic                bank_wbuf_rd_release_i,
  output logic                bank_wbuf_rd_rtn_valid_o,
  output logic [DATA_W-1:0]   bank_wbuf_rd_rtn_data_o,
  output logic [1:0]          bank_wbuf_rd_rtn_ch_id_o,
  output logic                bank_wbuf_rd_rtn_err_o,
  output logic [ID_W:0]       wbuf_occupancy_o,
  output logic                wbuf_err_o
);

  import mcash_pkg::*;

  localparam int W = CH_ID_W + DATA_W;
  localparam logic [ID_W:0] CNT_MAX = (ID_W+1)'(DEPTH);

  logic             rst_q;
  logic [DEPTH-1:0] occupied;
  logic             wr;
  logic             rd;
  logic             rd_hit;
  logic             wr_hit;
  logic             rel_ok;
  logic             bad_ch;
  logic [ID_W-1:0]  addr;
  logic [W-1:0]     rdata;

  assign rd     = bank_wbuf_rd_valid_i;
  assign xbar_wbuf_req_ready_o = !rst_q && !rd;
  assign wr     = xbar_wbuf_req_valid_i && xbar_wbuf_req_ready_o;
  assign rd_hit = occupied[bank_wbuf_rd_id_i];
  assign wr_hit = occupied[xbar_wbuf_req_wbuffer_id_i];
  assign rel_ok = rd && bank_wbuf_rd_release_i && rd_hit;
  assign bad_ch = 32'(xbar_wbuf_req_ch_id_i) >= NUM_CH;
  assign addr   = rd ? bank_wbuf_rd_id_i
                     : xbar_wbuf_req_wbuffer_id_i;

  mcash_wbuf_ram #(
    .DEPTH (DEPTH),
    .ID_W  (ID_W),
    .W     (W)
  ) u_ram (
    .clk_i   (clk_i),
    .rd_i    (rd),
    .wr_i    (wr),
    .addr_i  (addr),
    .wdata_i ({xbar_wbuf_req_ch_id_i,
               xbar_wbuf_req_data_i}),
    .rdata_o (rdata)
  );

  assign bank_wbuf_rd_rtn_data_o  = rdata[DATA_W-1:0];
  assign bank_wbuf_rd_rtn_ch_id_o = rdata[W-1 -: CH_ID_W];

  // Delayed reset holds ready low one cycle past deassertion.
  always_ff @(posedge clk_i) begin
    rst_q <= rst_i;
  end

  // Valid bits, occupancy, read-return flags and free pulses.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      occupied                 <= '0;
      wbuf_occupancy_o         <= '0;
      xbar_wbuf_rtn_free_id_o  <= '0;
      bank_wbuf_rd_rtn_valid_o <= 1'b0;
      bank_wbuf_rd_rtn_err_o   <= 1'b0;
      wbuf_err_o               <= 1'b0;
    end else begin
      xbar_wbuf_rtn_free_id_o  <= '0;
      bank_wbuf_rd_rtn_valid_o <= rd;
      bank_wbuf_rd_rtn_err_o   <= rd && !rd_hit;
      if (rel_ok) begin
        occupied[bank_wbuf_rd_id_i] <= 1'b0;
        xbar_wbuf_rtn_free_id_o[bank_wbuf_rd_id_i] <= 1'b1;
      end
      if (wr) begin
        occupied[xbar_wbuf_req_wbuffer_id_i] <= 1'b1;
      end
      if (wr && !wr_hit && wbuf_occupancy_o != CNT_MAX) begin
        wbuf_occupancy_o <= wbuf_occupancy_o + 1'b1;
      end else if (rel_ok && wbuf_occupancy_o != '0) begin
        wbuf_occupancy_o <= wbuf_occupancy_o - 1'b1;
      end
      if ((wr && (wr_hit || bad_ch)) || (rd && !rd_hit)) begin
        wbuf_err_o <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_mcash_wbuffer.sv
// Bench for mcash_wbuffer: directed steps plus random traffic
// checked against an array-based model of the buffer.
module tb_mcash_wbuffer;

  logic         clk = 1'b0;
  logic         rst;
  logic         wv;
  logic         ready;
  logic [1:0]   wch;
  logic [127:0] wdata;
  logic [7:0]   wid;
  logic [255:0] free_id;
  logic         rv;
  logic [7:0]   rid;
  logic         rel;
  logic         rtn_v;
  logic [127:0] rtn_d;
  logic [1:0]   rtn_ch;
  logic         rtn_err;
  logic [8:0]   occ;
  logic         err;

  int vecs = 0;
  int miss = 0;

  bit [255:0]   m_occ;
  logic [127:0] m_data [256];
  logic [1:0]   m_ch [256];
  bit           m_err;
  bit           m_rstq;

  always #5 clk = ~clk;

  mcash_wbuffer dut (
    .clk_i                      (clk),
    .rst_i                      (rst),
    .xbar_wbuf_req_valid_i      (wv),
    .xbar_wbuf_req_ready_o      (ready),
    .xbar_wbuf_req_ch_id_i      (wch),
    .xbar_wbuf_req_data_i       (wdata),
    .xbar_wbuf_req_wbuffer_id_i (wid),
    .xbar_wbuf_rtn_free_id_o    (free_id),
    .bank_wbuf_rd_valid_i       (rv),
    .bank_wbuf_rd_id_i          (rid),
    .bank_wbuf_rd_release_i     (rel),
    .bank_wbuf_rd_rtn_valid_o   (rtn_v),
    .bank_wbuf_rd_rtn_data_o    (rtn_d),
    .bank_wbuf_rd_rtn_ch_id_o   (rtn_ch),
    .bank_wbuf_rd_rtn_err_o     (rtn_err),
    .wbuf_occupancy_o           (occ),
    .wbuf_err_o                 (err)
  );

  task automatic chk(input string tag,
                     input logic [255:0] obs,
                     input logic [255:0] exp);
    vecs++;
    assert (obs === exp) else begin
      miss++;
      $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // One clock cycle: drive, predict, clock, compare.
  task automatic cyc(input bit r,
                     input bit w, input logic [7:0] wi,
                     input logic [1:0] wc, input logic [127:0] wd,
                     input bit rd, input logic [7:0] ri,
                     input bit rl);
    bit           acc;
    bit           e_rv;
    bit           e_re;
    logic [127:0] e_rd;
    logic [1:0]   e_rc;
    logic [255:0] e_free;
    rst = r; wv = w; wid = wi; wch = wc; wdata = wd;
    rv = rd; rid = ri; rel = rl;
    #1;
    acc = 1'b0;
    if (!r) begin
      chk("ready", 256'(ready), 256'(!m_rstq && !rd));
      acc = w && !m_rstq && !rd;
    end
    e_free = '0; e_rd = '0; e_rc = '0; e_re = 1'b0; e_rv = 1'b0;
    if (r) begin
      m_occ = '0;
      m_err = 1'b0;
      m_rstq = 1'b1;
    end else begin
      e_rv = rd;
      if (rd) begin
        e_re = !m_occ[ri];
        e_rd = m_data[ri];
        e_rc = m_ch[ri];
        if (!m_occ[ri]) m_err = 1'b1;
        else if (rl) begin
          e_free[ri] = 1'b1;
          m_occ[ri] = 1'b0;
        end
      end
      if (acc) begin
        if (m_occ[wi] || wc == 2'd3) m_err = 1'b1;
        m_occ[wi] = 1'b1;
        m_data[wi] = wd;
        m_ch[wi] = wc;
      end
      m_rstq = 1'b0;
    end
    @(posedge clk);
    #1;
    chk("rtn_valid", 256'(rtn_v), 256'(e_rv));
    chk("rtn_err", 256'(rtn_err), 256'(e_re));
    chk("free_id", free_id, e_free);
    chk("occupancy", 256'(occ), 256'($countones(m_occ)));
    chk("wbuf_err", 256'(err), 256'(m_err));
    if (e_rv && !e_re) begin
      chk("rtn_data", 256'(rtn_d), 256'(e_rd));
      chk("rtn_ch", 256'(rtn_ch), 256'(e_rc));
    end
  endtask

  task automatic idle();
    cyc(0, 0, 0, 0, '0, 0, 0, 0);
  endtask

  task automatic wr(input logic [7:0] i, input logic [1:0] c,
                    input logic [127:0] d);
    cyc(0, 1, i, c, d, 0, 0, 0);
  endtask

  task automatic rd(input logic [7:0] i, input bit rl);
    cyc(0, 0, 0, 0, '0, 1, i, rl);
  endtask

  initial begin
    logic [127:0] pat;
    m_occ = '0; m_err = 1'b0; m_rstq = 1'b1;
    cyc(1, 0, 0, 0, '0, 0, 0, 0);
    cyc(1, 0, 0, 0, '0, 0, 0, 0);
    idle();
    pat = {32{4'hA, 4'h5}};
    wr(8'h05, 2'd1, pat);
    rd(8'h05, 1);
    idle();

    wr(8'h07, 2'd2, rnd128());
    for (int i = 0; i < 3; i++)
      cyc(0, 1, 8'h08, 2'd0, 128'h1234, 1, 8'h07, 0);
    wr(8'h08, 2'd0, 128'h1234);
    rd(8'h08, 1);
    rd(8'h07, 1);

    for (int i = 0; i < 256; i++)
      wr(8'(i), 2'(i % 3), rnd128());
    idle();
    for (int i = 0; i < 256; i++)
      rd(8'(i), 1);
    idle();

    rd(8'h10, 1);
    idle();
    idle();

    wr(8'h20, 2'd1, rnd128());
    wr(8'h20, 2'd2, rnd128());
    rd(8'h20, 0);
    rd(8'h20, 1);
    wr(8'h21, 2'd3, rnd128());
    rd(8'h21, 1);

    cyc(1, 0, 0, 0, '0, 0, 0, 0);
    idle();
    for (int i = 0; i < 600; i++) begin
      bit w_en, r_en;
      w_en = ($urandom_range(0, 1) == 1);
      r_en = ($urandom_range(0, 2) == 0);
      cyc(0, w_en, 8'($urandom_range(0, 15)),
          2'($urandom_range(0, 9) == 0 ? 3 : $urandom_range(0, 2)),
          rnd128(), r_en, 8'($urandom_range(0, 15)),
          $urandom_range(0, 1) == 1);
    end

    wr(8'h33, 2'd0, rnd128());
    rd(8'h33, 1);
    cyc(1, 0, 0, 0, '0, 0, 0, 0);
    idle();
    idle();
    wr(8'h44, 2'd2, rnd128());
    rd(8'h44, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
    $finish;
  end

endmodule

// File: doc/mcash_wbuffer.md
Name: mcash_wbuffer

Overview:
Write-data buffer sitting directly downstream of the cross bar's write-buffer request port.
- Accepts 128-bit write data tagged with a pre-allocated wbuffer_id and stores it until the owning bank reads it out.
- On read-and-release it frees the entry and reports the freed id back to the cross bar's id allocator as a one-cycle pulse in a 256-bit free vector.
- Storage is modelled as single-ported: bank reads have priority over cross-bar writes.

Parameters:
DEPTH, 256, number of entries; must be a power of two, max 256.
ID_W, 8, width of wbuffer_id; ID_W = log2(DEPTH).
DATA_W, 128, write-data width.

Ports:
clk_i  in  1  clock.
rst_i  in  1  synchronous active-high reset.
xbar_wbuf_req_valid_i  in  1  write request valid.
xbar_wbuf_req_ready_o  out  1  write request accepted when valid&ready.
xbar_wbuf_req_ch_id_i  in  2  originating channel (0..2).
xbar_wbuf_req_data_i  in  DATA_W  write data.
xbar_wbuf_req_wbuffer_id_i  in  ID_W  target entry.
xbar_wbuf_rtn_free_id_o  out  DEPTH  one-hot-per-id free pulses.
bank_wbuf_rd_valid_i  in  1  bank read request; always accepted.
bank_wbuf_rd_id_i  in  ID_W  entry to read.
bank_wbuf_rd_release_i  in  1  free the entry after reading.
bank_wbuf_rd_rtn_valid_o  out  1  read data valid.
bank_wbuf_rd_rtn_data_o  out  DATA_W  read data.
bank_wbuf_rd_rtn_ch_id_o  out  2  channel stored with the entry.
bank_wbuf_rd_rtn_err_o  out  1  read hit an unoccupied entry.
wbuf_occupancy_o  out  ID_W+1  number of occupied entries.
wbuf_err_o  out  1  sticky protocol error.

Behaviour:
- Reset (clk_i edge with rst_i=1):
  - All occupied bits = 0; occupancy = 0; free vector = 0.
  - rd_rtn_valid = 0, rd_rtn_err = 0, wbuf_err = 0, ready = 0.
  - Data array is not reset.
  - An in-flight read return in the reset cycle is dropped.
- Ready:
  - ready = !rst_q && !bank_wbuf_rd_valid_i, where rst_q is rst_i registered.
  - Ready is low in the first cycle after reset deassertion.
  - A same-cycle bank read always blocks the write. This is combinational from rd_valid and is legal.
- Write (valid&ready):
  - At the next edge, entry[id] takes data and ch_id; occupied[id] is set.
  - If occupied[id] was already 1: overwrite anyway and set wbuf_err.
- Read (rd_valid):
  - Latency 1: next cycle rd_rtn_valid=1, with data and ch_id from entry[rd_id].
  - rd_rtn_err = !occupied[rd_id], sampled at request time. An errored read also sets wbuf_err.
  - Back-to-back reads give one return per cycle.
- Release (rd_valid & rd_release & occupied[rd_id]):
  - At the next edge occupied[rd_id] clears, and free_id[rd_id] pulses 1 for exactly one cycle, aligned with rd_rtn_valid.
  - Release of an unoccupied entry produces no pulse and sets wbuf_err.
- Free vector: at most one bit set per cycle; all bits 0 otherwise.
- Occupancy:
  - +1 on an accepted write to an unoccupied entry.
  - -1 on a valid release.
  - Writes and releases are never in the same cycle, so no simultaneous update occurs.
  - Saturates at DEPTH. DEPTH is reachable; 0 after reset.
- Re-allocation: an id freed at cycle N may be written at N+1 or later. No bypass is needed because writes land one edge after acceptance.
- ch_id = 3 on a write: stored unchanged and sets wbuf_err.
- wbuf_err clears only on reset.

Decomposition:
- Shared package mcash_pkg:
  - Constants WBUF_DEPTH=256, WBUF_ID_W=8, DATA_W=128, CH_ID_W=2, NUM_CH=3.
  - Typedef wbuf_id_t.
  - Typedef wbuf_entry_t {ch_id, data}.
- Sub-module mcash_wbuf_ram: single-port, DEPTH x (DATA_W+2), one read-or-write per cycle, registered read data. This keeps SRAM macro substitution isolated.
- Occupancy and valid-bit logic stay in the top.

Test Plan:
- Reset, then write id=0x05, ch=1, data=0xA5A5…; read id=0x05 with release=1 -> next cycle rtn_valid=1, data=0xA5A5…, ch_id=1, err=0, free_id[5]=1 for 1 cycle; occupancy 1->0.
- Write valid held while rd_valid=1 for 3 cycles -> ready=0 for those 3 cycles; write lands the cycle after rd_valid drops; read returns are unaffected.
- Fill all 256 ids -> occupancy=256, wbuf_err=0; release all -> 256 single-bit pulses in id order, occupancy=0.
- Read unwritten id=0x10 with release=1 -> rtn_err=1, no free pulse, wbuf_err=1 and stays set.
- Write id=0x20 twice without release -> wbuf_err=1; a later read returns the second data.
- Assert rst_i on the cycle after a read request -> rtn_valid=0, free vector=0, occupancy=0, ready=0 the cycle after reset, then 1.
